// File: rtl/fp_add_ctrl.sv
// Sequencing controller for a floating-point adder datapath: exponent compare,
// mantissa alignment, add, and normalization with overflow/underflow detection.
module fp_add_ctrl #(
  parameter int unsigned MAX_ALIGN = 24
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [7:0] exp_a,
  input  logic [7:0] exp_b,
  input  logic       sum_carry,
  input  logic       norm_msb,
  input  logic       norm_zero,
  output logic       busy,
  output logic       done,
  output logic       swap,
  output logic       align_load,
  output logic       align_shift,
  output logic       align_clear,
  output logic       norm_load,
  output logic       norm_shift_r,
  output logic       norm_shift_l,
  output logic [7:0] exp_out,
  output logic       overflow,
  output logic       underflow
);

  typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_ALIGN);

  state_t     state;
  logic [7:0] exp_reg;
  logic [7:0] cnt;
  logic       carry_q;
  logic       clear_q;

  logic       b_gt_a;
  logic [7:0] diff;
  logic [7:0] cnt_init;

  always_comb begin
    b_gt_a   = exp_b > exp_a;
    diff     = b_gt_a ? (exp_b - exp_a) : (exp_a - exp_b);
    cnt_init = (diff > MAX_CNT) ? MAX_CNT : diff;
  end

  assign busy    = (state != IDLE);
  assign exp_out = exp_reg;

  always_ff @(posedge clk) begin
    clear_q <= clear;
    if (clear) begin
      state        <= IDLE;
      exp_reg      <= '0;
      cnt          <= '0;
      carry_q      <= 1'b0;
      swap         <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      done         <= 1'b0;
      align_load   <= 1'b0;
      align_shift  <= 1'b0;
      align_clear  <= 1'b0;
      norm_load    <= 1'b0;
      norm_shift_r <= 1'b0;
      norm_shift_l <= 1'b0;
    end else begin
      done         <= 1'b0;
      align_load   <= 1'b0;
      align_shift  <= 1'b0;
      align_clear  <= 1'b0;
      norm_load    <= 1'b0;
      norm_shift_r <= 1'b0;
      norm_shift_l <= 1'b0;
      case (state)
        IDLE: begin
          // The first edge after clear only flushes the aligner; start waits.
          if (clear_q) begin
            align_clear <= 1'b1;
          end else if (start) begin
            swap       <= b_gt_a;
            exp_reg    <= b_gt_a ? exp_b : exp_a;
            cnt        <= cnt_init;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            align_load <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (cnt != '0) begin
            align_shift <= 1'b1;
            state       <= ALIGN;
          end else begin
            norm_load <= 1'b1;
            state     <= ADD;
          end
        end
        ALIGN: begin
          // Strobes are set one edge ahead, so the ALIGN dwell equals cnt.
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            norm_load <= 1'b1;
            state     <= ADD;
          end else begin
            align_shift <= 1'b1;
          end
        end
        ADD: begin
          carry_q <= sum_carry;
          state   <= NORM;
        end
        NORM: begin
          if (carry_q) begin
            carry_q      <= 1'b0;
            norm_shift_r <= 1'b1;
            if (exp_reg >= 8'd254) begin
              exp_reg  <= 8'd255;
              overflow <= 1'b1;
            end else begin
              exp_reg <= exp_reg + 8'd1;
            end
            done  <= 1'b1;
            state <= DONE;
          end else if (norm_zero) begin
            exp_reg <= '0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (norm_msb) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (exp_reg <= 8'd1) begin
            exp_reg   <= '0;
            underflow <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            norm_shift_l <= 1'b1;
            exp_reg      <= exp_reg - 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Randomized and directed bench for fp_add_ctrl against a cycle-count model
// derived from the exponent/normalization rules.
module tb_fp_add_ctrl;

  logic       clk = 1'b0;
  logic       clear, start, sum_carry, norm_msb, norm_zero;
  logic [7:0] exp_a, exp_b;
  logic       busy, done, swap;
  logic       align_load, align_shift, align_clear;
  logic       norm_load, norm_shift_r, norm_shift_l;
  logic [7:0] exp_out;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  localparam int NEVER = 9999;

  fp_add_ctrl #(.MAX_ALIGN(24)) dut (
    .clk(clk), .clear(clear), .start(start), .exp_a(exp_a), .exp_b(exp_b),
    .sum_carry(sum_carry), .norm_msb(norm_msb), .norm_zero(norm_zero),
    .busy(busy), .done(done), .swap(swap),
    .align_load(align_load), .align_shift(align_shift), .align_clear(align_clear),
    .norm_load(norm_load), .norm_shift_r(norm_shift_r), .norm_shift_l(norm_shift_l),
    .exp_out(exp_out), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  // Result of one add: alignment count, NORM cycles, final exponent and flags.
  function automatic void model(input int a, input int b, input int carry, input int k,
                                input int zi, output int cnt, output int n, output int e,
                                output int ovf, output int unf, output int shl,
                                output int shr, output int sw);
    int d;
    sw  = (b > a) ? 1 : 0;
    e   = (a > b) ? a : b;
    d   = (a > b) ? a - b : b - a;
    cnt = (d > 24) ? 24 : d;
    ovf = 0; unf = 0; shl = 0; shr = 0; n = 0;
    for (int i = 0; i < 400; i++) begin
      n++;
      if (carry != 0) begin
        shr = 1;
        if (e + 1 >= 255) begin e = 255; ovf = 1; end
        else e = e + 1;
        break;
      end
      if (i >= zi) begin e = 0; break; end
      if (i >= k) break;
      if (e <= 1) begin e = 0; unf = 1; break; end
      e = e - 1;
      shl++;
    end
  endfunction

  function automatic int strobes_bad();
    int s1, s2;
    s1 = int'(align_load) + int'(align_shift) + int'(align_clear);
    s2 = int'(norm_load) + int'(norm_shift_r) + int'(norm_shift_l);
    return (s1 > 1 || s2 > 1) ? 1 : 0;
  endfunction

  task automatic run_op(input int a, input int b, input int carry, input int k,
                        input int zi, input int poke);
    int cnt, n, e, ovf, unf, shl, shr, sw;
    int al_n, al_cyc, sh_n, sh_first, sh_last, nl_cyc, shl_n, shr_n, done_cyc;
    int excl_bad, busy_bad, ac_n;
    logic [7:0] eo;
    logic ov, un, sp;
    model(a, b, carry, k, zi, cnt, n, e, ovf, unf, shl, shr, sw);
    al_n = 0; al_cyc = -1; sh_n = 0; sh_first = -1; sh_last = -1; nl_cyc = -1;
    shl_n = 0; shr_n = 0; done_cyc = -1; excl_bad = 0; busy_bad = 0; ac_n = 0;
    eo = '0; ov = 1'b0; un = 1'b0; sp = 1'b0;
    @(posedge clk); #1;
    exp_a = 8'(a); exp_b = 8'(b); sum_carry = carry[0];
    norm_msb = 1'b0; norm_zero = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_a = 8'($urandom); exp_b = 8'($urandom);
    for (int c = 1; c <= 400; c++) begin
      norm_msb  = (c >= 3 + cnt + k);
      norm_zero = (c >= 3 + cnt + zi);
      start     = (poke != 0 && c == 2);
      @(negedge clk);
      excl_bad += strobes_bad();
      if (!busy) busy_bad++;
      if (align_clear) ac_n++;
      if (align_load) begin al_n++; al_cyc = c; end
      if (align_shift) begin
        sh_n++;
        if (sh_first < 0) sh_first = c;
        sh_last = c;
      end
      if (norm_load) nl_cyc = c;
      if (norm_shift_l) shl_n++;
      if (norm_shift_r) shr_n++;
      if (done) begin
        done_cyc = c; eo = exp_out; ov = overflow; un = underflow; sp = swap;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("align_load_cycle", al_cyc, 1);
    check_eq("align_load_count", al_n, 1);
    check_eq("align_shift_count", sh_n, cnt);
    check_eq("align_shift_span", (cnt > 0) ? sh_last - sh_first + 1 : 0, cnt);
    check_eq("align_shift_first", sh_first, (cnt > 0) ? 2 : -1);
    check_eq("norm_load_cycle", nl_cyc, 2 + cnt);
    check_eq("done_cycle", done_cyc, 3 + cnt + n);
    check_eq("shift_l_count", shl_n, shl);
    check_eq("shift_r_count", shr_n, shr);
    check_eq("exp_out", eo, e);
    check_eq("overflow", ov, ovf);
    check_eq("underflow", un, unf);
    check_eq("swap", sp, sw);
    check_eq("strobe_exclusive", excl_bad, 0);
    check_eq("busy_during_op", busy_bad, 0);
    check_eq("align_clear_op", ac_n, 0);
    @(posedge clk); #1;
    norm_msb = 1'b0; norm_zero = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);
    check_eq("hold_exp_out", exp_out, e);
    check_eq("hold_flags", {overflow, underflow}, {ovf[0], unf[0]});
  endtask

  task automatic check_quiet(input string tag, input logic ac_want);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_strobes"},
             {align_load, align_shift, align_clear, norm_load, norm_shift_r, norm_shift_l},
             {2'b00, ac_want, 3'b000});
    check_eq({tag, "_outs"}, {swap, exp_out, overflow, underflow}, '0);
  endtask

  initial begin
    int dn;
    clear = 1'b1; start = 1'b0; exp_a = '0; exp_b = '0;
    sum_carry = 1'b0; norm_msb = 1'b0; norm_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset", 1'b0);
    // Start held high across the release edge must be ignored.
    #1 clear = 1'b0; start = 1'b1;
    @(negedge clk);
    check_quiet("reset_release", 1'b1);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq("align_clear_once", align_clear, 0);

    run_op(127, 127, 0, 0, NEVER, 0);
    run_op(130, 127, 0, 0, NEVER, 0);
    run_op(127, 130, 0, 0, NEVER, 1);
    run_op(10, 50, 0, 0, NEVER, 0);
    run_op(254, 254, 1, 0, NEVER, 0);
    run_op(100, 100, 1, 0, NEVER, 0);
    run_op(100, 100, 0, 3, NEVER, 0);
    run_op(2, 2, 0, NEVER, NEVER, 0);
    run_op(60, 61, 0, NEVER, 2, 0);
    run_op(255, 0, 1, 0, NEVER, 1);

    for (int t = 0; t < 30; t++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255))
                                      : (a + int'($urandom_range(0, 6))) % 256;
      run_op(a, b, int'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : NEVER,
             int'($urandom_range(0, 1)));
    end

    // Abort during ALIGN: clear wins, no done pulse, then a clean recovery.
    @(posedge clk); #1;
    exp_a = 8'd127; exp_b = 8'd130; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    check_eq("abort_in_align", align_shift, 1);
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b1;
    @(negedge clk);
    check_quiet("abort", 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_quiet("abort_release", 1'b1);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check_eq("abort_no_done", dn, 0);

    run_op(130, 127, 0, 1, NEVER, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
